ahb_regfile_slave: RTL and testbench
====================================

AHB_REGFILE_SLAVE -- requirements
Module: ahb_regfile_slave

Interface
REQ-001 Parameter DATA_W, default 32: data bus width; legal values are 8, 16 and 32.
REQ-002 Parameter NUM_REGS, default 4: number of DATA_W-bit registers; index 0 is a read-only status register.
REQ-003 Parameter ADDR_W, default 4: byte-address width; ADDR_W SHALL be at least clog2(NUM_REGS*DATA_W/8).
REQ-004 Parameter WAIT_STATES, default 0: number of hreadyout-low cycles inserted before each OKAY completion; range 0-7.
REQ-005 hclk  in  1  the single clock; all state changes on its rising edge.
REQ-006 hreset  in  1  asynchronous, active-high reset.
REQ-007 hsel  in  1  slave select.
REQ-008 haddr  in  ADDR_W  byte address.
REQ-009 htrans  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 hwrite  in  1  1 = write, 0 = read.
REQ-011 hsize  in  3  transfer size, log2 of the byte count.
REQ-012 hwdata  in  DATA_W  write data, sampled in the data phase.
REQ-013 hready  in  1  bus-wide ready; address phase is sampled only when this is 1.
REQ-014 status_in  in  DATA_W  live value returned on reads of register 0.
REQ-015 hrdata  out  DATA_W  read data.
REQ-016 hreadyout  out  1  slave ready.
REQ-017 hresp  out  1  0 = OKAY, 1 = ERROR.
REQ-018 reg_out  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-019 wr_pulse  out  NUM_REGS  one-cycle strobe per register, asserted on a committed write.

Function
REQ-020 A transfer is accepted when, at a rising edge, hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize SHALL be registered at that edge.
REQ-021 IDLE and BUSY transfers, and cycles with hsel=0, SHALL get a zero-wait OKAY and cause no register change.
REQ-022 The register index is haddr[ADDR_W-1:clog2(DATA_W/8)]; the low address bits are the byte offset.
REQ-023 An accepted transfer is an error if any of these holds: hsize > clog2(DATA_W/8); the address is not aligned to 2**hsize; the index is >= NUM_REGS; it is a write to index 0.
REQ-024 The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-025 Output coding per state: IDLE gives hreadyout=1, hresp=0; WAIT gives hreadyout=0, hresp=0; DATA gives hreadyout=1, hresp=0; ERR1 gives hreadyout=0, hresp=1; ERR2 gives hreadyout=1, hresp=1.
REQ-026 On an accepted transfer, from IDLE, DATA or ERR2: if it is an error, go to ERR1; else if WAIT_STATES>0, go to WAIT with the counter loaded to WAIT_STATES-1; else go to DATA.
REQ-027 WAIT SHALL decrement the counter each cycle and go to DATA when the counter is 0.
REQ-028 ERR1 SHALL always go to ERR2; no transfer is accepted in ERR1 or WAIT, because hready is 0 there.
REQ-029 DATA and ERR2 with no new accepted transfer SHALL go to IDLE; with one, they follow REQ-026, so back-to-back transfers run with no bubble.
REQ-030 A write SHALL commit in the DATA cycle: only the byte lanes enabled by the registered hsize and offset are updated from hwdata, and wr_pulse[index] is asserted for that cycle.
REQ-031 A read SHALL drive hrdata in the DATA cycle with the full register, or status_in for index 0; hrdata SHALL be 0 in every other state.
REQ-032 An errored transfer SHALL change no register and assert no wr_pulse.
REQ-033 Byte-enable rule: the lanes from offset to offset+2**hsize-1 are enabled; lane k maps to bits [8k+7:8k].

Reset
REQ-034 While hreset=1, all of the following SHALL hold immediately, without waiting for a clock edge: state=IDLE, counter=0, all registers and reg_out=0, wr_pulse=0, hrdata=0, hreadyout=1, hresp=0.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer with no commit; the first accepted transfer after release is handled normally.

Structure
REQ-036 A shared package ahb_pkg SHALL hold the htrans encodings, the HRESP_OKAY and HRESP_ERROR constants, and the FSM state enum.
REQ-037 Byte-enable and misalignment decode SHALL live in the sub-module ahb_byte_strobe_gen, with inputs hsize and offset and outputs byte_en[DATA_W/8] and misaligned.

Verification (DATA_W=32, NUM_REGS=4, WAIT_STATES=2 unless stated)
REQ-038 Word write: addr 0x4, data 0xDEADBEEF -> hreadyout low for 2 cycles, then DATA with OKAY; reg_out[63:32]=0xDEADBEEF; wr_pulse=0010 for exactly 1 cycle.
REQ-039 Byte write: addr 0x9, hsize=0, data 0x0000AB00 -> only reg2[15:8]=0xAB; the other bytes of reg2 are unchanged.
REQ-040 Errors: write to 0x0, read of 0x10, or halfword at 0x5 -> ERR1 then ERR2 (hresp=1, with hreadyout 0 then 1); no register change.
REQ-041 WAIT_STATES=0: back-to-back write 0x4 then read 0x4 -> read hrdata equals the written data in the cycle after the write's DATA cycle, with no idle cycle between.
REQ-042 Reset mid-transfer: hreset=1 while in WAIT -> immediately hreadyout=1, hresp=0 and reg_out=0; the pending write never commits.
REQ-043 A read of 0x0 with status_in=0x12345678 -> hrdata=0x12345678 in the DATA cycle; BUSY or IDLE htrans -> zero-wait OKAY with no state change.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and register-file slave FSM state type
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// ahb_byte_strobe_gen: byte-lane enables and alignment check for one AHB transfer
module ahb_byte_strobe_gen #(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [2:0]       hsize,
    input  logic [OFF_W-1:0] offset,
    output logic [NB-1:0]    byte_en,
    output logic             misaligned
);
    // lanes offset .. offset + 2**hsize - 1 are written
    always_comb begin
        byte_en = '0;
        for (int k = 0; k < NB; k++)
            byte_en[k] = (k >= int'(offset)) && (k < int'(offset) + (1 << hsize));
    end
    assign misaligned = (int'(offset) & ((1 << hsize) - 1)) != 0;
endmodule

// File: rtl/ahb_regfile_slave.sv
// ahb_regfile_slave: AHB-Lite slave with a small register file, status at index 0 and programmable wait states
module ahb_regfile_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic                       hsel,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [DATA_W-1:0]          hwdata,
    input  logic                       hready,
    input  logic [DATA_W-1:0]          status_in,
    output logic [DATA_W-1:0]          hrdata,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int NB    = DATA_W / 8;
    localparam int LG    = $clog2(NB);
    localparam int OFF_W = (LG > 0) ? LG : 1;
    localparam int RI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t                state, state_d;
    logic [2:0]            cnt, cnt_d;
    logic                  a_write;
    logic [RI_W-1:0]       a_idx;
    logic [NB-1:0]         a_be, byte_en;
    logic                  misaligned, acc, err, commit;
    logic [ADDR_W-LG-1:0]  idx;
    logic [OFF_W-1:0]      off;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    assign idx = haddr[ADDR_W-1:LG];
    assign off = (LG > 0) ? haddr[OFF_W-1:0] : '0;

    ahb_byte_strobe_gen #(.DATA_W(DATA_W)) u_strobe (
        .hsize(hsize), .offset(off), .byte_en(byte_en), .misaligned(misaligned)
    );

    assign acc = hsel && hready && hreadyout && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign err = (int'(hsize) > LG) || misaligned || (int'(idx) >= NUM_REGS) || (hwrite && idx == '0);
    assign commit = (state == ST_DATA) && a_write;

    // next state: WAIT counts down, ERR1 always proceeds, other states take new transfers
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        if (state == ST_WAIT) begin
            state_d = (cnt == '0) ? ST_DATA : ST_WAIT;
            cnt_d = (cnt == '0) ? 3'd0 : cnt - 3'd1;
        end else if (state == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (acc) begin
            state_d = err ? ST_ERR1 : (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
            cnt_d = (!err && WAIT_STATES > 0) ? WS_LOAD : 3'd0;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // FSM state and address-phase capture
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_write <= 1'b0;
            a_idx   <= '0;
            a_be    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (acc) begin
                a_write <= hwrite;
                a_idx   <= idx[RI_W-1:0];
                a_be    <= byte_en;
            end
        end
    end

    // register file: enabled byte lanes take hwdata at the end of the DATA cycle
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NB; k++)
                if (a_be[k]) regs[a_idx][8*k +: 8] <= hwdata[8*k +: 8];
        end
    end

    assign wr_pulse  = commit ? (NUM_REGS'(1) << a_idx) : '0;
    assign hrdata    = (state == ST_DATA && !a_write) ? ((a_idx == '0) ? status_in : regs[a_idx]) : '0;
    assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
    assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_W +: DATA_W] = regs[i];
    end
endmodule

// File: tb/tb_ahb_regfile_slave.sv
// tb_ahb_regfile_slave: scoreboard bench for two slaves (2 wait states and zero wait states)
module tb_ahb_regfile_slave;
    typedef struct { bit w; logic [4:0] a; logic [2:0] sz; logic [31:0] wd; } xfer_t;
    typedef struct { bit w; bit err; logic [31:0] rd; int idx; int waits; } exp_t;

    logic hclk = 0, hreset = 0, hsel_w = 0, hsel_z = 0, hwrite = 0;
    logic [4:0] haddr = '0;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hsize = 3'd2;
    logic [31:0] hwdata = '0, status_in = '0;
    logic [31:0] rd_w, rd_z, hrdata;
    logic ho_w, ho_z, hr_w, hr_z, ho, hresp, hready;
    logic [127:0] ro_w, ro_z, reg_out;
    logic [3:0] wp_w, wp_z, wr_pulse;
    bit cur = 0;

    int checks = 0, errors = 0;
    xfer_t tq[$];
    exp_t sb[$];
    int done_cyc[$];
    logic [31:0] mdl [2][4];

    assign ho       = cur ? ho_z : ho_w;
    assign hresp    = cur ? hr_z : hr_w;
    assign hrdata   = cur ? rd_z : rd_w;
    assign reg_out  = cur ? ro_z : ro_w;
    assign wr_pulse = cur ? wp_z : wp_w;
    assign hready   = ho;

    ahb_regfile_slave #(.DATA_W(32), .NUM_REGS(4), .ADDR_W(5), .WAIT_STATES(2)) dut_w (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_w), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .status_in(status_in),
        .hrdata(rd_w), .hreadyout(ho_w), .hresp(hr_w), .reg_out(ro_w), .wr_pulse(wp_w));

    ahb_regfile_slave #(.DATA_W(32), .NUM_REGS(4), .ADDR_W(5), .WAIT_STATES(0)) dut_z (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_z), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .status_in(status_in),
        .hrdata(rd_z), .hreadyout(ho_z), .hresp(hr_z), .reg_out(ro_z), .wr_pulse(wp_z));

    always #5 hclk = ~hclk;

    function automatic bit m_err(bit w, logic [4:0] a, logic [2:0] sz);
        int off = int'(a[1:0]);
        int i = int'(a[4:2]);
        return sz > 3'd2 || (off % (1 << sz)) != 0 || i >= 4 || (w && i == 0);
    endfunction

    task automatic set_sel(bit s);
        hsel_w = s && !cur;
        hsel_z = s && cur;
    endtask

    task automatic clear_model(int d);
        for (int i = 0; i < 4; i++) mdl[d][i] = '0;
    endtask

    task automatic push_exp(xfer_t t);
        exp_t e;
        int off = int'(t.a[1:0]);
        e.w = t.w;
        e.idx = int'(t.a[4:2]);
        e.err = m_err(t.w, t.a, t.sz);
        e.waits = e.err ? 1 : (cur ? 0 : 2);
        e.rd = (e.idx == 0) ? status_in : (e.idx < 4) ? mdl[cur][e.idx] : 32'h0;
        if (!e.err && t.w)
            for (int b = 0; b < 4; b++)
                if (b >= off && b < off + (1 << t.sz)) mdl[cur][e.idx][8*b +: 8] = t.wd[8*b +: 8];
        sb.push_back(e);
    endtask

    task automatic run();
        xfer_t dp, nx;
        exp_t e;
        bit dp_v = 0, nx_v = 0;
        int waits = 0, cyc = 0, n = 0;
        logic [3:0] wp_exp;
        logic [31:0] rd_exp;
        done_cyc.delete();
        while ((tq.size() > 0 || dp_v || nx_v) && cyc < 200) begin
            @(negedge hclk);
            cyc++;
            if (nx_v) begin dp = nx; dp_v = 1; nx_v = 0; waits = 0; end
            if (dp_v) begin
                hwdata = dp.wd;
                if (!ho) begin
                    waits++;
                    checks++;
                    if (hresp !== sb[0].err) begin errors++; $display("FAIL wait_hresp xfer%0d: got %b want %b", n, hresp, sb[0].err); end
                end else begin
                    e = sb.pop_front();
                    wp_exp = (e.w && !e.err) ? 4'(1 << e.idx) : 4'h0;
                    rd_exp = (!e.w && !e.err) ? e.rd : 32'h0;
                    checks += 4;
                    if (hresp !== e.err) begin errors++; $display("FAIL hresp xfer%0d: got %b want %b", n, hresp, e.err); end
                    if (waits != e.waits) begin errors++; $display("FAIL waits xfer%0d: got %0d want %0d", n, waits, e.waits); end
                    if (hrdata !== rd_exp) begin errors++; $display("FAIL hrdata xfer%0d: got %h want %h", n, hrdata, rd_exp); end
                    if (wr_pulse !== wp_exp) begin errors++; $display("FAIL wr_pulse xfer%0d: got %b want %b", n, wr_pulse, wp_exp); end
                    done_cyc.push_back(cyc);
                    dp_v = 0;
                    n++;
                end
            end
            if (ho) begin
                if (tq.size() > 0) begin
                    nx = tq.pop_front();
                    nx_v = 1;
                    set_sel(1);
                    htrans = 2'b10;
                    haddr = nx.a;
                    hwrite = nx.w;
                    hsize = nx.sz;
                    push_exp(nx);
                end else begin
                    set_sel(0);
                    htrans = 2'b00;
                end
            end
        end
        if (cyc >= 200) begin
            errors++;
            $display("FAIL timeout: got %0d cycles want < 200", cyc);
            tq.delete();
            sb.delete();
            set_sel(0);
            htrans = 2'b00;
        end
        @(negedge hclk);
    endtask

    task automatic check_regs(string nm);
        logic [127:0] m = {mdl[cur][3], mdl[cur][2], mdl[cur][1], mdl[cur][0]};
        checks++;
        if (reg_out !== m) begin errors++; $display("FAIL %s reg_out: got %h want %h", nm, reg_out, m); end
    endtask

    task automatic test_reset();
        #1 hreset = 1;
        #1;
        checks += 10;
        if (ho_w !== 1'b1 || ho_z !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b%b want 11", ho_w, ho_z); end
        if (hr_w !== 1'b0 || hr_z !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b%b want 00", hr_w, hr_z); end
        if (rd_w !== '0) begin errors++; $display("FAIL reset_hrdata_w: got %h want 0", rd_w); end
        if (rd_z !== '0) begin errors++; $display("FAIL reset_hrdata_z: got %h want 0", rd_z); end
        if (ro_w !== '0) begin errors++; $display("FAIL reset_reg_out_w: got %h want 0", ro_w); end
        if (ro_z !== '0) begin errors++; $display("FAIL reset_reg_out_z: got %h want 0", ro_z); end
        if (wp_w !== '0) begin errors++; $display("FAIL reset_wr_pulse_w: got %b want 0", wp_w); end
        if (wp_z !== '0) begin errors++; $display("FAIL reset_wr_pulse_z: got %b want 0", wp_z); end
        if (dut_w.hrdata !== rd_w) begin errors++; $display("FAIL reset_port_w: got %h want %h", dut_w.hrdata, rd_w); end
        if (ho_w !== ho_z) begin errors++; $display("FAIL reset_ready_eq: got %b want %b", ho_w, ho_z); end
        clear_model(0);
        clear_model(1);
        repeat (2) @(negedge hclk);
        hreset = 0;
        @(negedge hclk);
    endtask

    task automatic test_word_write();
        cur = 0;
        tq.push_back('{1'b1, 5'h04, 3'd2, 32'hDEADBEEF});
        run();
        checks += 2;
        if (ro_w[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_write reg1: got %h want deadbeef", ro_w[63:32]); end
        if (wp_w !== 4'b0000) begin errors++; $display("FAIL word_write pulse_len: got %b want 0000", wp_w); end
        check_regs("word_write");
    endtask

    task automatic test_byte_write();
        cur = 0;
        tq.push_back('{1'b1, 5'h08, 3'd2, 32'h11223344});
        tq.push_back('{1'b1, 5'h09, 3'd0, 32'h0000AB00});
        tq.push_back('{1'b0, 5'h08, 3'd2, 32'h0});
        run();
        checks++;
        if (ro_w[95:64] !== 32'h1122AB44) begin errors++; $display("FAIL byte_write reg2: got %h want 1122ab44", ro_w[95:64]); end
        check_regs("byte_write");
    endtask

    task automatic test_errors();
        cur = 0;
        tq.push_back('{1'b1, 5'h00, 3'd2, 32'hFFFFFFFF});
        tq.push_back('{1'b0, 5'h10, 3'd2, 32'h0});
        tq.push_back('{1'b1, 5'h05, 3'd1, 32'h5A5A5A5A});
        tq.push_back('{1'b0, 5'h08, 3'd3, 32'h0});
        tq.push_back('{1'b1, 5'h16, 3'd2, 32'h01010101});
        run();
        check_regs("errors");
    endtask

    task automatic test_status_read();
        cur = 0;
        status_in = 32'h12345678;
        tq.push_back('{1'b0, 5'h00, 3'd2, 32'h0});
        tq.push_back('{1'b0, 5'h03, 3'd0, 32'h0});
        run();
        status_in = 32'hA5A50F0F;
        tq.push_back('{1'b0, 5'h00, 3'd2, 32'h0});
        run();
    endtask

    task automatic test_busy_idle();
        cur = 0;
        set_sel(1);
        htrans = 2'b01;
        hwrite = 1;
        haddr = 5'h04;
        hsize = 3'd2;
        hwdata = 32'hFFFFFFFF;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) htrans = 2'b00;
            if (c == 4) begin set_sel(0); htrans = 2'b10; end
            @(negedge hclk);
            checks++;
            if (ho !== 1'b1 || hresp !== 1'b0 || wr_pulse !== 4'b0) begin
                errors++;
                $display("FAIL busy_idle c%0d: got ready=%b resp=%b pulse=%b want 1 0 0000", c, ho, hresp, wr_pulse);
            end
        end
        htrans = 2'b00;
        @(negedge hclk);
        check_regs("busy_idle");
    endtask

    task automatic test_random();
        cur = 0;
        for (int i = 0; i < 12; i++)
            tq.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 3'($urandom_range(0, 3)), 32'($urandom)});
        run();
        check_regs("random");
    endtask

    task automatic test_back_to_back();
        cur = 1;
        tq.push_back('{1'b1, 5'h04, 3'd2, 32'hCAFEF00D});
        tq.push_back('{1'b0, 5'h04, 3'd2, 32'h0});
        tq.push_back('{1'b1, 5'h0E, 3'd1, 32'hBEEF0000});
        tq.push_back('{1'b0, 5'h0C, 3'd2, 32'h0});
        run();
        for (int i = 1; i < done_cyc.size(); i++) begin
            checks++;
            if (done_cyc[i] - done_cyc[i-1] != 1) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 1", i, done_cyc[i] - done_cyc[i-1]); end
        end
        check_regs("back_to_back");
        cur = 0;
    endtask

    task automatic test_reset_mid();
        cur = 0;
        tq.push_back('{1'b1, 5'h0C, 3'd2, 32'h5555AAAA});
        run();
        set_sel(1);
        htrans = 2'b10;
        hwrite = 1;
        haddr = 5'h08;
        hsize = 3'd2;
        @(negedge hclk);
        set_sel(0);
        htrans = 2'b00;
        hwdata = 32'h77777777;
        checks++;
        if (ho_w !== 1'b0) begin errors++; $display("FAIL reset_mid in_wait: got %b want 0", ho_w); end
        #1 hreset = 1;
        #1;
        checks += 4;
        if (ho_w !== 1'b1) begin errors++; $display("FAIL reset_mid hreadyout: got %b want 1", ho_w); end
        if (hr_w !== 1'b0) begin errors++; $display("FAIL reset_mid hresp: got %b want 0", hr_w); end
        if (ro_w !== '0) begin errors++; $display("FAIL reset_mid reg_out: got %h want 0", ro_w); end
        if (wp_w !== '0) begin errors++; $display("FAIL reset_mid wr_pulse: got %b want 0", wp_w); end
        clear_model(0);
        repeat (2) @(negedge hclk);
        hreset = 0;
        repeat (3) @(negedge hclk);
        check_regs("reset_mid_no_commit");
    endtask

    task automatic test_after_reset();
        cur = 0;
        tq.push_back('{1'b1, 5'h08, 3'd2, 32'h0BADF00D});
        tq.push_back('{1'b0, 5'h08, 3'd2, 32'h0});
        run();
        check_regs("after_reset");
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_errors();
        test_status_read();
        test_busy_idle();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
